// File: rtl/ascon_pkg.sv
// Shared ASCON types and constants for the init, absorb and finalization stages.
package ascon_pkg;

  typedef logic [4:0][63:0] ascon_state_t;

  localparam int unsigned NUM_ROUNDS = 12;

  localparam logic [7:0] ROUND_CONST [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  typedef enum logic {
    BlkAd = 1'b0,
    BlkPt = 1'b1
  } blk_kind_e;

  typedef enum logic [2:0] {
    StIdle,
    StAdWait,
    StPermute,
    StPtWait,
    StDone
  } absorb_state_e;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round: constant addition, bit-sliced S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   rnd_i,
  output ascon_state_t state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_i[0];
    x1 = state_i[1];
    x2 = state_i[2] ^ {56'h0, ROUND_CONST[rnd_i]};
    x3 = state_i[3];
    x4 = state_i[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    state_o[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    state_o[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    state_o[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    state_o[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
  end

endmodule

// File: rtl/ascon_absorb.sv
// ASCON absorb stage: AD absorption, domain separation and PT->CT encryption with p^b between
// blocks. Define ASCON_UNROLL2_EN to run two rounds per cycle (ROUNDS_B must then be even).
module ascon_absorb
  import ascon_pkg::*;
#(
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         state_valid_i,
  output logic         state_ready_o,
  input  ascon_state_t state_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [63:0]  blk_data_i,
  input  logic         blk_is_pt_i,
  input  logic         blk_last_i,
  output logic         ct_valid_o,
  input  logic         ct_ready_i,
  output logic [63:0]  ct_data_o,
  output logic         done_o,
  output ascon_state_t state_o
);

  if (ROUNDS_B == 0 || ROUNDS_B > NUM_ROUNDS) begin : g_bad_rounds
    $error("ROUNDS_B must lie in 1..12");
  end

  localparam logic [3:0] RndFirst = 4'(NUM_ROUNDS - ROUNDS_B);
`ifdef ASCON_UNROLL2_EN
  localparam logic [3:0] RndStep = 4'd2;
  if (ROUNDS_B % 2 != 0) begin : g_odd_rounds
    $error("ROUNDS_B must be even when two rounds run per cycle");
  end
`else
  localparam logic [3:0] RndStep = 4'd1;
`endif
  localparam logic [3:0] RndLast = 4'(NUM_ROUNDS - RndStep);

  absorb_state_e fsm_q, fsm_d;
  ascon_state_t  state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          sep_pending_q, sep_pending_d;
  logic          phase_pt_q, phase_pt_d;
  logic          fin_pending_q, fin_pending_d;
  logic [63:0]   ct_data_q, ct_data_d;
  logic          ct_valid_q, ct_valid_d;

  ascon_state_t  rnd0_out, perm_out;
  ascon_state_t  pt_base;
  logic [63:0]   pt_ct;
  logic          pt_accept;

  ascon_round u_round0 (
    .state_i (state_q),
    .rnd_i   (rnd_q),
    .state_o (rnd0_out)
  );

`ifdef ASCON_UNROLL2_EN
  logic [3:0] rnd_hi;
  assign rnd_hi = rnd_q + 4'd1;

  ascon_round u_round1 (
    .state_i (rnd0_out),
    .rnd_i   (rnd_hi),
    .state_o (perm_out)
  );
`else
  assign perm_out = rnd0_out;
`endif

  assign pt_ct = pt_base[0] ^ blk_data_i;

  always_comb begin
    fsm_d         = fsm_q;
    state_d       = state_q;
    rnd_d         = rnd_q;
    sep_pending_d = sep_pending_q;
    phase_pt_d    = phase_pt_q;
    fin_pending_d = fin_pending_q;
    ct_data_d     = ct_data_q;
    ct_valid_d    = ct_valid_q;
    state_ready_o = 1'b0;
    blk_ready_o   = 1'b0;
    done_o        = 1'b0;
    pt_accept     = 1'b0;
    pt_base       = state_q;

    // CT drains independently of the FSM, so permutation overlaps consumer backpressure.
    if (ct_valid_q && ct_ready_i) begin
      ct_valid_d = 1'b0;
    end

    unique case (fsm_q)
      StIdle, StDone: begin
        state_ready_o = 1'b1;
        done_o        = (fsm_q == StDone);
        if (state_valid_i) begin
          state_d       = state_i;
          rnd_d         = RndFirst;
          sep_pending_d = 1'b0;
          phase_pt_d    = 1'b0;
          fin_pending_d = 1'b0;
          fsm_d         = StAdWait;
        end
      end

      StAdWait: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin
          if (blk_kind_e'(blk_is_pt_i) == BlkPt) begin
            // No AD at all: domain separation folds into this PT block's cycle.
            pt_accept  = 1'b1;
            pt_base[4] = state_q[4] ^ 64'd1;
          end else begin
            state_d[0]    = state_q[0] ^ blk_data_i;
            sep_pending_d = blk_last_i;
            phase_pt_d    = 1'b0;
            rnd_d         = RndFirst;
            fsm_d         = StPermute;
          end
        end
      end

      StPermute: begin
        state_d = perm_out;
        rnd_d   = rnd_q + RndStep;
        if (rnd_q == RndLast) begin
          rnd_d = RndFirst;
          if (sep_pending_q) begin
            state_d[4]    = perm_out[4] ^ 64'd1;
            sep_pending_d = 1'b0;
            phase_pt_d    = 1'b1;
            fsm_d         = StPtWait;
          end else begin
            fsm_d = phase_pt_q ? StPtWait : StAdWait;
          end
        end
      end

      StPtWait: begin
        if (fin_pending_q) begin
          if (!ct_valid_q || ct_ready_i) begin
            fin_pending_d = 1'b0;
            fsm_d         = StDone;
          end
        end else begin
          blk_ready_o = (blk_kind_e'(blk_is_pt_i) == BlkPt) && !(ct_valid_q && !ct_ready_i);
          pt_accept   = blk_valid_i && blk_ready_o;
        end
      end

      default: fsm_d = StIdle;
    endcase

    if (pt_accept) begin
      state_d    = pt_base;
      state_d[0] = pt_ct;
      ct_data_d  = pt_ct;
      ct_valid_d = 1'b1;
      phase_pt_d = 1'b1;
      if (blk_last_i) begin
        fin_pending_d = 1'b1;
        fsm_d         = StPtWait;
      end else begin
        rnd_d = RndFirst;
        fsm_d = StPermute;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q         <= StIdle;
      state_q       <= '0;
      rnd_q         <= '0;
      sep_pending_q <= 1'b0;
      phase_pt_q    <= 1'b0;
      fin_pending_q <= 1'b0;
      ct_data_q     <= '0;
      ct_valid_q    <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      rnd_q         <= rnd_d;
      sep_pending_q <= sep_pending_d;
      phase_pt_q    <= phase_pt_d;
      fin_pending_q <= fin_pending_d;
      ct_data_q     <= ct_data_d;
      ct_valid_q    <= ct_valid_d;
    end
  end

  assign ct_valid_o = ct_valid_q;
  assign ct_data_o  = ct_data_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_ascon_absorb.sv
// Self-checking bench for ascon_absorb: directed vectors, CT/final-state scoreboard.
module tb_ascon_absorb;
  import ascon_pkg::*;

  localparam int RB = 6;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         state_valid_i = 1'b0;
  logic         state_ready_o;
  ascon_state_t state_i = '0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [63:0]  blk_data_i = '0;
  logic         blk_is_pt_i = 1'b0;
  logic         blk_last_i = 1'b0;
  logic         ct_valid_o;
  logic         ct_ready_i = 1'b1;
  logic [63:0]  ct_data_o;
  logic         done_o;
  ascon_state_t state_o;

  int checks = 0;
  int errors = 0;

  logic [63:0]  exp_ct[$];
  ascon_state_t exp_fin[$];
  ascon_state_t m_state;
  logic         m_in_ad;
  logic         done_seen = 1'b0;

  logic [4:0] sbox_tab [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  ascon_absorb #(.ROUNDS_B(RB)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .state_valid_i (state_valid_i),
    .state_ready_o (state_ready_o),
    .state_i       (state_i),
    .blk_valid_i   (blk_valid_i),
    .blk_ready_o   (blk_ready_o),
    .blk_data_i    (blk_data_i),
    .blk_is_pt_i   (blk_is_pt_i),
    .blk_last_i    (blk_last_i),
    .ct_valid_o    (ct_valid_o),
    .ct_ready_i    (ct_ready_i),
    .ct_data_o     (ct_data_o),
    .done_o        (done_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (table S-box, column-wise) ----------------
  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    logic [127:0] w;
    w = {v, v};
    return w[n +: 64];
  endfunction

  function automatic ascon_state_t m_round(input ascon_state_t s, input int r);
    ascon_state_t t;
    logic [4:0] col, o;
    s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
    for (int i = 0; i < 64; i++) begin
      col = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
      o = sbox_tab[col];
      t[0][i] = o[4]; t[1][i] = o[3]; t[2][i] = o[2]; t[3][i] = o[1]; t[4][i] = o[0];
    end
    s[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
    s[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
    s[2] = t[2] ^ rr(t[2], 1) ^ rr(t[2], 6);
    s[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
    s[4] = t[4] ^ rr(t[4], 7) ^ rr(t[4], 41);
    return s;
  endfunction

  function automatic ascon_state_t m_perm(input ascon_state_t s);
    for (int r = 12 - RB; r < 12; r++) s = m_round(s, r);
    return s;
  endfunction

  function automatic ascon_state_t mk(input logic [63:0] a0, input logic [63:0] a1,
                                      input logic [63:0] a2, input logic [63:0] a3,
                                      input logic [63:0] a4);
    ascon_state_t s;
    s[0] = a0; s[1] = a1; s[2] = a2; s[3] = a3; s[4] = a4;
    return s;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input ascon_state_t act,
                             input ascon_state_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic load_state(input ascon_state_t s);
    int n = 0;
    @(posedge clk); #1;
    state_i = s;
    state_valid_i = 1'b1;
    @(negedge clk);
    while (!state_ready_o && n < 50) begin @(negedge clk); n++; end
    check64("load_ready", state_ready_o, 1);
    @(posedge clk); #1;
    state_valid_i = 1'b0;
    m_state = s;
    m_in_ad = 1'b1;
  endtask

  task automatic send_blk(input logic [63:0] d, input logic is_pt, input logic last);
    int n = 0;
    logic [63:0] ct;
    @(posedge clk); #1;
    blk_data_i = d; blk_is_pt_i = is_pt; blk_last_i = last; blk_valid_i = 1'b1;
    @(negedge clk);
    while (!blk_ready_o && n < 100) begin @(negedge clk); n++; end
    check64("blk_accept", blk_ready_o, 1);
    @(posedge clk); #1;
    blk_valid_i = 1'b0;
    if (!is_pt) begin
      m_state[0] = m_state[0] ^ d;
      m_state = m_perm(m_state);
      if (last) begin
        m_state[4] = m_state[4] ^ 64'd1;
        m_in_ad = 1'b0;
      end
    end else begin
      if (m_in_ad) begin
        m_state[4] = m_state[4] ^ 64'd1;
        m_in_ad = 1'b0;
      end
      ct = m_state[0] ^ d;
      exp_ct.push_back(ct);
      m_state[0] = ct;
      if (last) exp_fin.push_back(m_state);
      else m_state = m_perm(m_state);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 40) begin @(negedge clk); n++; end
    check64("done_reached", done_o, 1);
  endtask

  task automatic wait_blk_ready(output int n);
    n = 0;
    while (!blk_ready_o && n < 40) begin n++; @(negedge clk); end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_i) begin
        done_seen = 1'b0;
      end else begin
        if (ct_valid_o && ct_ready_i) begin
          if (exp_ct.size() == 0) begin
            checks++; errors++;
            $display("FAIL ct_unexpected: got %h expected none", ct_data_o);
          end else begin
            check64("ct_data", ct_data_o, exp_ct.pop_front());
          end
        end
        if (done_o && !done_seen) begin
          if (exp_fin.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got done_o=1 expected no completion");
          end else begin
            check_state("final_state", state_o, exp_fin.pop_front());
          end
        end
        done_seen = done_o;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    ascon_state_t s;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check64("rst_state_ready", state_ready_o, 1);
    check64("rst_blk_ready", blk_ready_o, 0);
    check64("rst_done", done_o, 0);
    check64("rst_ct_valid", ct_valid_o, 0);
    check_state("rst_state", state_o, '0);

    // Reset during round 3 of PERMUTE, then recovery below
    load_state(mk(64'hA5A5A5A5A5A5A5A5, 64'h1, 64'h2, 64'h3, 64'h4));
    send_blk(64'h0F0F0F0F0F0F0F0F, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check64("midrst_state_ready", state_ready_o, 1);
    check64("midrst_blk_ready", blk_ready_o, 0);
    check64("midrst_ct_valid", ct_valid_o, 0);
    check64("midrst_ct_data", ct_data_o, 0);
    check64("midrst_done", done_o, 0);
    check_state("midrst_state", state_o, '0);

    // All-zero state, single last PT, no AD
    load_state(mk(64'h0, 64'h0, 64'h0, 64'h0, 64'h0));
    ct_ready_i = 1'b0;
    send_blk(64'h0123456789ABCDEF, 1'b1, 1'b1);
    @(negedge clk);
    check64("t1_ct_valid", ct_valid_o, 1);
    check64("t1_ct_data", ct_data_o, 64'h0123456789ABCDEF);
    check64("t1_x4", state_o[4], 64'h1);
    check64("t1_x0", state_o[0], 64'h0123456789ABCDEF);
    check64("t1_done_early", done_o, 0);
    @(negedge clk);
    check64("t1_done_held", done_o, 0);
    @(posedge clk); #1;
    ct_ready_i = 1'b1;
    @(posedge clk); #1;
    check64("t1_done", done_o, 1);

    // Single non-last AD: 6-cycle busy window, XOR visible in x0 before round 1
    load_state(mk(64'hFFFF0000FFFF0000, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                  64'h0, 64'h8000000000000001));
    send_blk(64'h0000FFFF0000FFFF, 1'b0, 1'b0);
    @(negedge clk);
    check64("t2_x0_round_in", state_o[0], 64'hFFFFFFFFFFFFFFFF);
    wait_blk_ready(n);
    check64("t2_busy_cycles", 64'(n), 64'(RB));
    check_state("t2_state", state_o, m_state);
    send_blk(64'h8000000000000000, 1'b0, 1'b1);
    send_blk(64'h5555AAAA5555AAAA, 1'b1, 1'b1);
    wait_done();

    // Two AD + two PT blocks, golden values from the bench model
    load_state(mk(64'h80400C0600000000, 64'h0011223344556677, 64'h8899AABBCCDDEEFF,
                  64'h0F1E2D3C4B5A6978, 64'h1032547698BADCFE));
    send_blk(64'h4153434F4E2D3132, 1'b0, 1'b0);
    send_blk(64'h3880000000000000, 1'b0, 1'b1);
    send_blk(64'h48656C6C6F2C2057, 1'b1, 1'b0);
    send_blk(64'h6F726C6480000000, 1'b1, 1'b1);
    wait_done();

    // CT backpressure: ct_ready_i low 10 cycles
    load_state(mk(64'h1111111111111111, 64'h0, 64'hC0FFEE0000C0FFEE, 64'h0, 64'h0));
    ct_ready_i = 1'b0;
    send_blk(64'h2222222222222222, 1'b1, 1'b0);
    blk_data_i = 64'h4444444444444444; blk_is_pt_i = 1'b1; blk_last_i = 1'b1;
    blk_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check64("t4_ct_stable", ct_data_o, 64'h3333333333333333);
      check64("t4_ct_valid", ct_valid_o, 1);
      check64("t4_no_accept", blk_ready_o, 0);
      check64("t4_done_low", done_o, 0);
    end
    @(posedge clk); #1;
    blk_valid_i = 1'b0;
    ct_ready_i = 1'b1;
    send_blk(64'h4444444444444444, 1'b1, 1'b1);
    wait_done();

    // state_valid_i during PERMUTE is ignored
    load_state(mk(64'h0123012301230123, 64'h4567456745674567, 64'h89AB89AB89AB89AB,
                  64'hCDEFCDEFCDEFCDEF, 64'h0));
    send_blk(64'hDEADBEEFDEADBEEF, 1'b0, 1'b0);
    @(posedge clk); #1;
    state_i = mk(64'hBAD0, 64'hBAD1, 64'hBAD2, 64'hBAD3, 64'hBAD4);
    state_valid_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    state_valid_i = 1'b0;
    @(negedge clk);
    wait_blk_ready(n);
    check_state("t6_state", state_o, m_state);
    send_blk(64'h0102030405060708, 1'b0, 1'b1);
    send_blk(64'hA0B0C0D0E0F00010, 1'b1, 1'b1);
    wait_done();

    n = 0;
    while ((exp_ct.size() != 0 || exp_fin.size() != 0) && n < 50) begin
      @(negedge clk); n++;
    end
    check64("ct_queue_empty", 64'(exp_ct.size()), 0);
    check64("fin_queue_empty", 64'(exp_fin.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
